// File: rtl/rv_ifetch.sv
// rv_ifetch: instruction fetch initiator with credit-limited imem requests, in-order word buffer
// and redirect flush that drops responses still in flight.
module rv_ifetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  output logic        imem_resp_ready,
  input  logic [31:0] imem_resp_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          r_run;
  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [31:0]   r_fpc  [FIFO_DEPTH];
  logic [31:0]   r_fins [FIFO_DEPTH];

  logic          w_empty;
  logic          w_req_fire;
  logic          w_resp_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_sum;
  logic [OW-1:0] w_out_nxt;
  logic [31:0]   w_redir_pc;

  // Credits count both in-flight requests and buffered words, so every response has a slot.
  assign w_empty        = r_cnt == '0;
  assign w_sum          = {{(CW + 1 - OW){1'b0}}, r_out} + {1'b0, r_cnt};
  assign imem_req_valid = r_run & ~redirect_valid & (w_sum < (CW + 1)'(FIFO_DEPTH))
                        & (r_out < OW'(MAX_OUTSTANDING));
  assign imem_req_addr  = r_run ? r_pc : '0;
  assign imem_resp_ready = r_run;
  assign if_valid       = ~w_empty & ~redirect_valid;
  assign if_pc          = w_empty ? '0 : r_fpc[r_rp];
  assign if_instr       = w_empty ? '0 : r_fins[r_rp];

  assign w_req_fire  = imem_req_valid & imem_req_ready;
  assign w_resp_fire = imem_resp_valid & imem_resp_ready & (r_out != '0);
  assign w_push      = w_resp_fire & ~redirect_valid & (r_drop == '0);
  assign w_pop       = if_valid & if_ready;
  assign w_out_nxt   = r_out + OW'(w_req_fire) - OW'(w_resp_fire);
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_drop    <= '0;
      r_cnt     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_nxt;
      if (redirect_valid) begin
        r_pc      <= w_redir_pc;
        r_resp_pc <= w_redir_pc;
        r_drop    <= w_out_nxt;
        r_cnt     <= '0;
        r_wp      <= '0;
        r_rp      <= '0;
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_resp_fire && r_drop != '0) r_drop <= r_drop - OW'(1);
        if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
        if (w_push) r_wp <= (FIFO_DEPTH == 1) ? '0 : r_wp + AW'(1);
        if (w_pop) r_rp <= (FIFO_DEPTH == 1) ? '0 : r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end

  always_ff @(posedge clk)
    if (w_push) begin
      r_fpc[r_wp]  <= r_resp_pc;
      r_fins[r_wp] <= imem_resp_rdata;
    end
endmodule

// File: tb/tb_rv_ifetch.sv
// tb_rv_ifetch: directed plus randomised scenarios against an in-order imem responder;
// a golden sequential pc model feeds the expected queue, a monitor pops it on every decode handshake.
module tb_rv_ifetch;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  rv_ifetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
    .imem_resp_rdata(imem_resp_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  typedef struct {logic [31:0] addr; int t;} req_t;

  ent_t        exp_q[$];
  req_t        pend[$];
  ent_t        mon_e;
  logic [31:0] gen_pc;
  int errors = 0, checks = 0, pops = 0, accepts = 0, cyc = 0;
  int wmin = 0, wmax = 0, rr_pct = 100, p0 = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_000A;
    if (a == 32'h8) return 32'h0022_1820;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: gen_pc, ins: mem(gen_pc)});
      gen_pc += 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
    refill();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk(!imem_req_valid, "rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk(!imem_resp_ready, "rst_resp_ready", 32'(imem_resp_ready), 32'h0);
    chk(!if_valid, "rst_if_valid", 32'(if_valid), 32'h0);
    chk(imem_req_addr == 32'h0, "rst_req_addr", imem_req_addr, 32'h0);
    chk(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
    chk(if_instr == 32'h0, "rst_if_instr", if_instr, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    restart(32'h0);
    accepts = 0;
    pops = 0;
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    restart(pc);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Scoreboard monitor: each decode handshake must match the head of the expected stream.
  initial forever begin
    @(negedge clk);
    if (rst_n && if_valid && if_ready) begin
      mon_e = exp_q.pop_front();
      chk(if_pc == mon_e.pc, "if_pc", if_pc, mon_e.pc);
      chk(if_instr == mon_e.ins, "if_instr", if_instr, mon_e.ins);
      pops++;
      refill();
    end
  end

  // In-order responder with per-request wait; also checks the request-hold and credit rules.
  initial begin
    bit rf, sf, hold_pend;
    logic [31:0] ra, hold_addr;
    hold_pend = 1'b0;
    hold_addr = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      rf = imem_req_valid & imem_req_ready;
      ra = imem_req_addr;
      sf = imem_resp_valid & imem_resp_ready;
      if (rst_n && hold_pend && !redirect_valid)
        chk(imem_req_valid && imem_req_addr == hold_addr, "req_hold", imem_req_addr, hold_addr);
      hold_pend = rst_n && imem_req_valid && !imem_req_ready;
      hold_addr = imem_req_addr;
      if (rst_n) chk(pend.size() <= MAXO, "outstanding_max", 32'(pend.size()), 32'(MAXO));
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) pend.delete();
      else begin
        if (sf && pend.size() > 0) void'(pend.pop_front());
        if (rf) begin
          pend.push_back('{addr: ra, t: cyc + int'($urandom_range(wmax, wmin))});
          accepts++;
        end
      end
      imem_resp_valid = pend.size() > 0 && pend[0].t <= cyc;
      imem_resp_rdata = imem_resp_valid ? mem(pend[0].addr) : 32'h0;
      imem_req_ready = $urandom_range(99) < rr_pct;
    end
  end

  initial begin
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    restart(32'h0);
    do_reset();
    @(negedge clk);
    chk(!imem_req_valid, "req_before_run", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    chk(imem_req_valid, "req_first", 32'(imem_req_valid), 32'h1);
    chk(imem_req_addr == 32'h0, "req_first_addr", imem_req_addr, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk(pops >= 5, "t1_progress", 32'(pops), 32'd5);

    if_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(!imem_req_valid, "t2_req_stall", 32'(imem_req_valid), 32'h0);
    chk(if_valid, "t2_if_valid", 32'(if_valid), 32'h1);
    chk(if_pc == 32'h0, "t2_head_pc", if_pc, 32'h0);
    chk(if_instr == 32'h2001_0005, "t2_head_instr", if_instr, 32'h2001_0005);
    chk(accepts == 2, "t2_accepts", 32'(accepts), 32'd2);
    @(posedge clk); #1;
    if_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk(pops >= 4, "t2_progress", 32'(pops), 32'd4);

    wmin = 3;
    wmax = 3;
    do_reset();
    repeat (30) begin
      @(negedge clk);
      if (pops > 0) break;
    end
    chk(pops > 0, "t3_first_pop", 32'(pops), 32'd1);
    @(posedge clk); #1;
    redirect(32'h0000_0043);
    @(negedge clk);
    chk(imem_req_addr == 32'h40, "t4_redirect_addr", imem_req_addr, 32'h40);
    p0 = pops;
    repeat (30) @(posedge clk);
    #1;
    chk(pops >= p0 + 3, "t3_progress", 32'(pops), 32'(p0 + 3));
    redirect(32'hFFFF_FFFC);
    p0 = pops;
    repeat (30) @(posedge clk);
    #1;
    chk(pops >= p0 + 3, "t4_wrap_progress", 32'(pops), 32'(p0 + 3));

    if_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if_ready = 1'b1;
    do_reset();
    repeat (25) @(posedge clk);
    #1;
    chk(pops >= 3, "t5_restart_progress", 32'(pops), 32'd3);

    wmin = 0;
    wmax = 5;
    rr_pct = 70;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if_ready = $urandom_range(99) < 70;
      if ($urandom_range(99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15))
                                               : 32'($urandom_range(1023));
        restart(redirect_pc);
      end else redirect_valid = 1'b0;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk(pops >= 100, "t6_progress", 32'(pops), 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
